// File: rtl/entropy_harvest_pkg.sv
// Shared constants and types for the entropy harvester: PRNG state width,
// health-test default and the von Neumann FSM state encoding.
package entropy_harvest_pkg;

   localparam int unsigned PRNG_STATE_BITS   = 32;
   localparam int unsigned REP_LIMIT_DEFAULT = 16;

   typedef enum logic {
      StIdle      = 1'b0,
      StHaveFirst = 1'b1
   } vn_state_e;

endpackage

// File: rtl/entropy_harvest_if.sv
// Bundle of the harvester's noise, pool and health signals; the consumer side
// drives noise/controls (master), the harvester implements the slave side.
interface entropy_harvest_if #(
   parameter int unsigned NOISE_BITS = 8,
   parameter int unsigned POOL_BITS  = 32
);

   logic [NOISE_BITS-1:0] noise;
   logic                  enable;
   logic                  entropy;
   logic [POOL_BITS-1:0]  pool;
   logic                  pool_valid;
   logic                  pool_read;
   logic                  health_fail;
   logic                  health_clr;

   modport master (
      output noise, enable, pool_read, health_clr,
      input  entropy, pool, pool_valid, health_fail
   );

   modport slave (
      input  noise, enable, pool_read, health_clr,
      output entropy, pool, pool_valid, health_fail
   );

endinterface

// File: rtl/entropy_harvest_vn_debias.sv
// Von Neumann extractor: pairs consecutive enabled raw samples and emits the
// first bit of each unequal pair as a one-cycle registered pulse.
module entropy_harvest_vn_debias
   import entropy_harvest_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_enable,
   input  logic i_raw,
   output logic o_bit,
   output logic o_bit_valid
);

   vn_state_e r_state;
   logic      r_first;
   logic      r_bit;
   logic      r_bit_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_first     <= 1'b0;
         r_bit       <= 1'b0;
         r_bit_valid <= 1'b0;
      end else begin
         r_bit_valid <= 1'b0;
         if (!i_enable) begin
            // Dropping enable abandons any half-collected pair.
            r_state <= StIdle;
         end else begin
            case (r_state)
               StIdle: begin
                  r_first <= i_raw;
                  r_state <= StHaveFirst;
               end
               StHaveFirst: begin
                  if (i_raw != r_first) begin
                     r_bit       <= r_first;
                     r_bit_valid <= 1'b1;
                  end
                  r_state <= StIdle;
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign o_bit       = r_bit;
   assign o_bit_valid = r_bit_valid;

endmodule

// File: rtl/entropy_harvest.sv
// Entropy harvester: synchronizes noise, debiases its parity, fills a reseed
// pool and blocks output when a repetition-count health test trips.
module entropy_harvest
   import entropy_harvest_pkg::*;
#(
   parameter int unsigned NOISE_BITS = 8,
   parameter int unsigned POOL_BITS  = PRNG_STATE_BITS,
   parameter int unsigned REP_LIMIT  = REP_LIMIT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   entropy_harvest_if.slave  bus
);

   localparam int unsigned RunW  = $clog2(REP_LIMIT + 1);
   localparam int unsigned FillW = $clog2(POOL_BITS + 1);

   logic [NOISE_BITS-1:0] r_sync1;
   logic [NOISE_BITS-1:0] r_sync2;
   logic [RunW-1:0]       r_run;
   logic                  r_last;
   logic                  r_fail;
   logic [FillW-1:0]      r_fill;
   logic [POOL_BITS-1:0]  r_pool;

   logic                  w_raw;
   logic                  w_bit;
   logic                  w_bit_valid;
   logic                  w_produce;
   logic                  w_full;
   logic                  w_read;
   logic                  w_hit;
   logic [RunW-1:0]       w_run_next;

   assign w_raw = ^r_sync2;

   entropy_harvest_vn_debias u_vn_debias (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_enable    (bus.enable),
      .i_raw       (w_raw),
      .o_bit       (w_bit),
      .o_bit_valid (w_bit_valid)
   );

   // A zero run means no sample yet since reset/enable, so the next one starts a run of 1.
   always_comb begin
      w_run_next = RunW'(1);
      if (r_run != '0 && w_raw == r_last) begin
         w_run_next = (r_run == RunW'(REP_LIMIT)) ? r_run : r_run + RunW'(1);
      end
   end

   assign w_hit     = bus.enable & (w_run_next == RunW'(REP_LIMIT));
   assign w_full    = (r_fill == FillW'(POOL_BITS));
   assign w_produce = w_bit_valid & ~r_fail;
   assign w_read    = bus.pool_read & w_full & ~r_fail;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_run   <= '0;
         r_last  <= 1'b0;
         r_fail  <= 1'b0;
         r_fill  <= '0;
         r_pool  <= '0;
      end else begin
         r_sync1 <= bus.noise;
         r_sync2 <= r_sync1;
         if (bus.enable) begin
            r_run  <= w_run_next;
            r_last <= w_raw;
         end else begin
            r_run  <= '0;
         end
         // A fresh limit hit outranks a simultaneous clear.
         r_fail <= w_hit | (r_fail & ~bus.health_clr);
         if (w_read) begin
            r_fill <= w_produce ? FillW'(1) : '0;
         end else if (w_produce && !w_full) begin
            r_fill <= r_fill + FillW'(1);
         end
         if (w_produce) begin
            r_pool <= {r_pool[POOL_BITS-2:0], w_bit};
         end
      end
   end

   assign bus.entropy     = w_bit_valid & w_bit & ~r_fail;
   assign bus.pool        = r_pool;
   assign bus.pool_valid  = w_full;
   assign bus.health_fail = r_fail;

endmodule

// File: tb/tb_entropy_harvest.sv
// Self-checking bench for entropy_harvest: directed table, corner sequences and
// randomized noise against a queue-based behavioural model.
module tb_entropy_harvest;

   localparam int unsigned NB    = 8;
   localparam int unsigned PB    = 32;
   localparam int unsigned LIMIT = 16;

   typedef struct {
      logic [NB-1:0] noise;
      logic          enable;
      logic          exp_entropy;
      logic [PB-1:0] exp_pool;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   // Behavioural model state
   bit          m_pipe0, m_pipe1;
   bit          m_pair_q[$];
   bit          m_pend, m_bit;
   int          m_run;
   bit          m_last;
   bit          m_fail;
   bit [PB-1:0] m_pool;
   int          m_fill;

   bit          feed_q[$];
   bit          saw_entropy;
   vec_t        tbl[11];

   entropy_harvest_if #(.NOISE_BITS(NB), .POOL_BITS(PB)) bus ();

   entropy_harvest #(
      .NOISE_BITS (NB),
      .POOL_BITS  (PB),
      .REP_LIMIT  (LIMIT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pipe0 = 0; m_pipe1 = 0; m_pair_q.delete();
      m_pend = 0; m_bit = 0; m_run = 0; m_last = 0;
      m_fail = 0; m_pool = '0; m_fill = 0;
   endtask

   // One clock edge of the reference behaviour, using the inputs presented at that edge.
   task automatic model_step();
      bit raw;
      bit produced;
      bit hit;
      raw      = m_pipe1;
      produced = m_pend && !m_fail;
      hit      = 0;
      if (!m_fail) begin
         if (bus.pool_read && m_fill == PB) m_fill = produced ? 1 : 0;
         else if (produced && m_fill < PB) m_fill++;
         if (produced) m_pool = {m_pool[PB-2:0], m_bit};
      end
      m_pend = 0;
      if (bus.enable) begin
         m_pair_q.push_back(raw);
         if (m_pair_q.size() == 2) begin
            if (m_pair_q[0] != m_pair_q[1]) begin
               m_pend = 1;
               m_bit  = m_pair_q[0];
            end
            m_pair_q.delete();
         end
         if (m_run != 0 && raw == m_last) m_run = (m_run < LIMIT) ? m_run + 1 : m_run;
         else m_run = 1;
         m_last = raw;
         hit    = (m_run == LIMIT);
      end else begin
         m_pair_q.delete();
         m_run = 0;
      end
      m_fail  = hit || (m_fail && !bus.health_clr);
      m_pipe1 = m_pipe0;
      m_pipe0 = ^bus.noise;
   endtask

   task automatic compare_all();
      check("entropy", 32'(bus.entropy), 32'(m_pend && m_bit && !m_fail));
      check("pool", bus.pool, m_pool);
      check("pool_valid", 32'(bus.pool_valid), 32'(m_fill == PB));
      check("health_fail", 32'(bus.health_fail), 32'(m_fail));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      bus.noise = '0; bus.enable = 0; bus.pool_read = 0; bus.health_clr = 0;
      #2;
      rst_n = 0;
      model_reset();
      #1;
      compare_all();
      #2;
      rst_n = 1;
   endtask

   // Each queued bit reaches the extractor as a raw sample; noise parity carries the bit.
   task automatic feed_raw(input int read_at);
      int            n;
      logic [NB-1:0] v;
      n = feed_q.size();
      saw_entropy = 0;
      for (int i = 0; i < n + 3; i++) begin
         v = NB'($urandom);
         if (i < n) v[0] = (^v[NB-1:1]) ^ feed_q[i];
         else v = '0;
         bus.noise     = v;
         bus.enable    = (i >= 2 && i < n + 2);
         bus.pool_read = (i == read_at);
         tick();
         if (bus.entropy) saw_entropy = 1;
      end
      bus.enable = 0; bus.pool_read = 0; bus.noise = '0;
   endtask

   initial begin
      logic [31:0] word;
      int          stuck_len;
      logic [NB-1:0] held;
      n_checks = 0;
      n_errors = 0;
      bus.noise = '0; bus.enable = 0; bus.pool_read = 0; bus.health_clr = 0;
      rst_n = 0;
      model_reset();
      #2;
      check("rst_entropy", 32'(bus.entropy), 32'h0);
      check("rst_pool", bus.pool, 32'h0);
      check("rst_valid", 32'(bus.pool_valid), 32'h0);
      check("rst_fail", 32'(bus.health_fail), 32'h0);
      #4;
      rst_n = 1;

      // Pair decode: raw 0,1 1,0 1,1 0,0 sampled on edges 2..9
      tbl[0]  = '{8'h00, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{8'h01, 1'b0, 1'b0, 32'h0};
      tbl[2]  = '{8'h01, 1'b1, 1'b0, 32'h0};
      tbl[3]  = '{8'h00, 1'b1, 1'b0, 32'h0};
      tbl[4]  = '{8'h01, 1'b1, 1'b0, 32'h0};
      tbl[5]  = '{8'h01, 1'b1, 1'b1, 32'h0};
      tbl[6]  = '{8'h00, 1'b1, 1'b0, 32'h1};
      tbl[7]  = '{8'h00, 1'b1, 1'b0, 32'h1};
      tbl[8]  = '{8'h00, 1'b1, 1'b0, 32'h1};
      tbl[9]  = '{8'h00, 1'b1, 1'b0, 32'h1};
      tbl[10] = '{8'h00, 1'b0, 1'b0, 32'h1};
      for (int i = 0; i < 11; i++) begin
         bus.noise  = tbl[i].noise;
         bus.enable = tbl[i].enable;
         tick();
         check("tbl_entropy", 32'(bus.entropy), 32'(tbl[i].exp_entropy));
         check("tbl_pool", bus.pool, tbl[i].exp_pool);
      end
      bus.enable = 0;

      // Stuck source: fail on the 16th enabled sample, nothing enters the pool
      do_reset();
      bus.enable = 1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         check("stuck_fail", 32'(bus.health_fail), 32'(k >= 16));
         check("stuck_entropy", 32'(bus.entropy), 32'h0);
         check("stuck_pool", bus.pool, 32'h0);
      end

      // Pool fill with 32'hA5A5A5A5, MSB first
      do_reset();
      word = 32'hA5A5A5A5;
      feed_q.delete();
      for (int b = 31; b >= 0; b--) begin
         feed_q.push_back(word[b]);
         feed_q.push_back(!word[b]);
      end
      feed_raw(-1);
      check("fill_pool", bus.pool, 32'hA5A5A5A5);
      check("fill_valid", 32'(bus.pool_valid), 32'h1);

      // Read collides with a new bit while full
      feed_q.delete();
      feed_q.push_back(1'b1);
      feed_q.push_back(1'b0);
      feed_raw(4);
      check("coll_pulse", 32'(saw_entropy), 32'h1);
      check("coll_valid", 32'(bus.pool_valid), 32'h0);
      check("coll_pool", bus.pool, 32'h4B4B4B4B);

      // Reset after the first sample (1) of a pair
      bus.noise = 8'h01; tick();
      bus.noise = 8'h00; tick();
      bus.enable = 1;    tick();
      do_reset();
      check("mid_entropy", 32'(bus.entropy), 32'h0);
      check("mid_pool", bus.pool, 32'h0);
      check("mid_valid", 32'(bus.pool_valid), 32'h0);
      check("mid_fail", 32'(bus.health_fail), 32'h0);
      feed_q.delete();
      feed_q.push_back(1'b0);
      feed_q.push_back(1'b0);
      feed_raw(-1);
      check("mid_stale_pair", 32'(saw_entropy), 32'h0);
      feed_q.delete();
      feed_q.push_back(1'b1);
      feed_q.push_back(1'b0);
      feed_raw(-1);
      check("mid_fresh_pair", 32'(saw_entropy), 32'h1);

      // health_clr on the cycle the run reaches the limit
      do_reset();
      bus.enable = 1;
      for (int k = 1; k < 16; k++) tick();
      check("clr_pre_fail", 32'(bus.health_fail), 32'h0);
      bus.health_clr = 1;
      tick();
      check("clr_collide", 32'(bus.health_fail), 32'h1);
      bus.health_clr = 0;
      bus.enable = 0;
      tick();
      check("clr_held", 32'(bus.health_fail), 32'h1);
      bus.health_clr = 1;
      bus.noise = 8'h5A;
      tick();
      bus.health_clr = 0;
      check("clr_cleared", 32'(bus.health_fail), 32'h0);
      feed_q.delete();
      feed_q.push_back(1'b1);
      feed_q.push_back(1'b0);
      feed_raw(-1);
      check("clr_resume", 32'(saw_entropy), 32'h1);

      // Randomized traffic with occasional stuck bursts
      do_reset();
      stuck_len = 0;
      held = '0;
      for (int c = 0; c < 4000; c++) begin
         if (stuck_len == 0 && $urandom_range(0, 150) == 0) begin
            stuck_len = $urandom_range(10, 24);
            held = NB'($urandom);
         end
         if (stuck_len > 0) begin
            bus.noise = held;
            stuck_len--;
         end else begin
            bus.noise = NB'($urandom);
         end
         bus.enable     = ($urandom_range(0, 9) != 0);
         bus.pool_read  = ($urandom_range(0, 5) == 0);
         bus.health_clr = ($urandom_range(0, 40) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
